// File: rtl/vga_frame_sched_if.sv
// Updater <-> scheduler ownership handshake for the shared tile/frame state.
interface vga_frame_sched_if;
  logic upd_req;
  logic upd_gnt;
  logic upd_overrun;

  modport master (output upd_req, input upd_gnt, input upd_overrun);
  modport slave  (input upd_req, output upd_gnt, output upd_overrun);
endinterface

// File: rtl/vga_frame_sched.sv
// 640x480@60 raster timing plus vblank-only arbitration of the shared state.
// Optional: define VGA_FRAME_SCHED_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_frame_sched #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start,
`ifdef VGA_FRAME_SCHED_FRAME_CNT_EN
  output logic [15:0] frame_count,
`endif
  vga_frame_sched_if.slave upd
);

  localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FP_AT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SY_AT  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_AT  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_FP_AT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SY_AT  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_AT  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ON  = 1'(SYNC_POL);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_e;
  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_GRANT, ARB_HOLD} arb_e;

  logic [9:0] h_q, h_d, v_q, v_d;
  phase_e     h_ph_q, h_ph_d, v_ph_q, v_ph_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
  arb_e       arb_q, arb_d;
  logic       gnt_q, gnt_d, overrun_q, overrun_d;
  logic       h_wrap, frame_wrap, vblank_ok;
`ifdef VGA_FRAME_SCHED_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

  function automatic phase_e next_phase(input logic [9:0] cnt, input phase_e cur,
                                        input logic [9:0] fp_at, input logic [9:0] sy_at,
                                        input logic [9:0] bp_at);
    phase_e ph;
    if (cnt == 10'd0) ph = PH_ACTIVE;
    else if (cnt == fp_at) ph = PH_FP;
    else if (cnt == sy_at) ph = PH_SYNC;
    else if (cnt == bp_at) ph = PH_BP;
    else ph = cur;
    return ph;
  endfunction

  assign h_wrap     = (h_q == H_LAST);
  assign frame_wrap = h_wrap && (v_q == V_LAST);
  // The last vblank line is excluded so a grant can never straddle the frame wrap.
  assign vblank_ok  = (v_q >= V_FP_AT) && (v_q != V_LAST);

  // Raster next-state: counters, phases and outputs derived from the next count.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    h_ph_d        = h_ph_q;
    v_ph_d        = v_ph_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
`ifdef VGA_FRAME_SCHED_FRAME_CNT_EN
    frame_cnt_d   = frame_cnt_q;
`endif
    if (pix_en) begin
      if (h_wrap) begin
        h_d = 10'd0;
        if (v_q == V_LAST) v_d = 10'd0;
        else v_d = v_q + 10'd1;
        v_ph_d = next_phase(v_d, v_ph_q, V_FP_AT, V_SY_AT, V_BP_AT);
      end else begin
        h_d    = h_q + 10'd1;
        v_d    = v_q;
        v_ph_d = v_ph_q;
      end
      h_ph_d        = next_phase(h_d, h_ph_q, H_FP_AT, H_SY_AT, H_BP_AT);
      hsync_d       = (h_ph_d == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
      vsync_d       = (v_ph_d == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
      video_on_d    = (h_ph_d == PH_ACTIVE) && (v_ph_d == PH_ACTIVE);
      line_start_d  = h_wrap;
      frame_start_d = frame_wrap;
`ifdef VGA_FRAME_SCHED_FRAME_CNT_EN
      frame_cnt_d   = frame_wrap ? (frame_cnt_q + 16'd1) : frame_cnt_q;
`endif
    end else begin
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // Arbiter next-state; a release on the frame-wrap edge takes priority over revocation.
  always_comb begin
    arb_d     = arb_q;
    gnt_d     = gnt_q;
    overrun_d = 1'b0;
    if (pix_en) begin
      case (arb_q)
        ARB_IDLE: begin
          if (upd.upd_req && vblank_ok) arb_d = ARB_GRANT;
          else if (upd.upd_req) arb_d = ARB_WAIT;
          else arb_d = ARB_IDLE;
        end
        ARB_WAIT: begin
          if (!upd.upd_req) arb_d = ARB_IDLE;
          else if (vblank_ok) arb_d = ARB_GRANT;
          else arb_d = ARB_WAIT;
        end
        ARB_GRANT: begin
          if (!upd.upd_req) begin
            arb_d = ARB_IDLE;
          end else if (frame_wrap) begin
            arb_d     = ARB_HOLD;
            overrun_d = 1'b1;
          end else begin
            arb_d = ARB_GRANT;
          end
        end
        ARB_HOLD: begin
          if (!upd.upd_req) arb_d = ARB_IDLE;
          else arb_d = ARB_HOLD;
        end
        default: arb_d = ARB_IDLE;
      endcase
      gnt_d = (arb_d == ARB_GRANT);
    end else begin
      arb_d = arb_q;
      gnt_d = gnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      h_ph_q        <= PH_ACTIVE;
      v_ph_q        <= PH_ACTIVE;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      video_on_q    <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      arb_q         <= ARB_IDLE;
      gnt_q         <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef VGA_FRAME_SCHED_FRAME_CNT_EN
      frame_cnt_q   <= 16'd0;
`endif
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      h_ph_q        <= h_ph_d;
      v_ph_q        <= v_ph_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      arb_q         <= arb_d;
      gnt_q         <= gnt_d;
      overrun_q     <= overrun_d;
`ifdef VGA_FRAME_SCHED_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign h_count         = h_q;
  assign v_count         = v_q;
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign video_on        = video_on_q;
  assign line_start      = line_start_q;
  assign frame_start     = frame_start_q;
  assign upd.upd_gnt     = gnt_q;
  assign upd.upd_overrun = overrun_q;
`ifdef VGA_FRAME_SCHED_FRAME_CNT_EN
  assign frame_count     = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_frame_sched.sv
// Scoreboard bench for vga_frame_sched on a shrunken raster so whole frames fit in a short run.
module tb_vga_frame_sched;

  localparam int HA = 16, HFP = 4, HS = 6, HBP = 5, HT = HA + HFP + HS + HBP;
  localparam int VA = 12, VFP = 3, VS = 2, VBP = 4, VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  logic clk, rst, pix_en;
  logic [9:0] h_count, v_count;
  logic hsync, vsync, video_on, line_start, frame_start;
`ifdef VGA_FRAME_SCHED_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  vga_frame_sched_if bus ();

  vga_frame_sched #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_count(h_count), .v_count(v_count),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .line_start(line_start), .frame_start(frame_start),
`ifdef VGA_FRAME_SCHED_FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .upd(bus)
  );

  typedef struct {
    int h; int v; int hs; int vs; int von; int ls; int fs; int gnt; int ov; int fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  // Reference model: position as a step index within the frame, arbiter as ownership flags.
  int   m_n = 0, m_fc = 0;
  bit   m_owned = 0, m_blocked = 0, m_ls = 0, m_fs = 0, m_ov = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_step(input logic en, input logic req, input logic r);
    int cur_v, nn;
    if (r) begin
      m_n = 0; m_fc = 0; m_owned = 0; m_blocked = 0; m_ls = 0; m_fs = 0; m_ov = 0;
    end else if (en) begin
      cur_v = m_n / HT;
      nn    = (m_n + 1) % FT;
      m_ov  = 0;
      if (!req) begin
        m_owned = 0; m_blocked = 0;
      end else if (m_owned && nn == 0) begin
        m_owned = 0; m_blocked = 1; m_ov = 1;
      end else if (!m_owned && !m_blocked && cur_v >= VA && cur_v != VT - 1) begin
        m_owned = 1;
      end
      m_n  = nn;
      m_ls = ((m_n % HT) == 0);
      m_fs = (m_n == 0);
      if (m_fs) m_fc = (m_fc + 1) % 65536;
    end else begin
      m_ls = 0; m_fs = 0; m_ov = 0;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.h   = m_n % HT;
    e.v   = m_n / HT;
    e.hs  = (e.h >= HA + HFP && e.h < HA + HFP + HS) ? 0 : 1;
    e.vs  = (e.v >= VA + VFP && e.v < VA + VFP + VS) ? 0 : 1;
    e.von = (e.h < HA && e.v < VA) ? 1 : 0;
    e.ls  = int'(m_ls);
    e.fs  = int'(m_fs);
    e.gnt = int'(m_owned);
    e.ov  = int'(m_ov);
    e.fc  = m_fc;
    return e;
  endfunction

  task automatic drive(input logic en, input logic req, input logic r);
    @(negedge clk);
    pix_en      = en;
    bus.upd_req = req;
    rst         = r;
    model_step(en, req, r);
    exp_q.push_back(model_out());
  endtask

  task automatic goto_pos(input int th, input int tv, input logic req);
    int k;
    k = 0;
    while (!((m_n % HT) == th && (m_n / HT) == tv) && k <= FT) begin
      drive(1'b1, req, 1'b0);
      k++;
    end
    if (k > FT) begin
      n_checks++;
      n_err++;
      $display("FAIL goto_pos h=%0d v=%0d not reached within %0d steps", th, tv, FT);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("h_count",     int'(h_count),         e.h);
        chk("v_count",     int'(v_count),         e.v);
        chk("hsync",       int'(hsync),           e.hs);
        chk("vsync",       int'(vsync),           e.vs);
        chk("video_on",    int'(video_on),        e.von);
        chk("line_start",  int'(line_start),      e.ls);
        chk("frame_start", int'(frame_start),     e.fs);
        chk("upd_gnt",     int'(bus.upd_gnt),     e.gnt);
        chk("upd_overrun", int'(bus.upd_overrun), e.ov);
        chk("gnt_during_video", int'(bus.upd_gnt && video_on), 0);
`ifdef VGA_FRAME_SCHED_FRAME_CNT_EN
        chk("frame_count", int'(frame_count),     e.fc);
`endif
      end
    end
  end

  // Stimulus: directed raster/arbiter scenarios followed by a randomized stretch.
  initial begin
    logic rq;
    rst = 1'b1; pix_en = 1'b0; bus.upd_req = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    repeat (2 * FT) drive(1'b1, 1'b0, 1'b0);
    repeat (FT) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    // Request during active video, release mid-vblank.
    goto_pos(5, 7, 1'b0);
    goto_pos(0, VA + 5, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    goto_pos(0, 0, 1'b0);
    // Hold through frame wrap, then re-request in the next vblank and overrun again.
    goto_pos(2, 3, 1'b0);
    goto_pos(0, 0, 1'b1);
    goto_pos(0, VA + 2, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    goto_pos(0, 0, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    // Reset while granted.
    goto_pos(0, VA + 4, 1'b1);
    goto_pos(7, VA + 6, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    goto_pos(3, 2, 1'b0);
    // First request on the last vblank line waits for the next vblank.
    goto_pos(0, VT - 1, 1'b0);
    goto_pos(0, VA + 2, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    // Freeze behaviour while granted.
    goto_pos(0, VA + 1, 1'b1);
    repeat (4) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    // Randomized pix_en, request toggles and rare resets.
    rq = 1'b0;
    repeat (4 * FT) begin
      if ($urandom_range(39) == 0) rq = ~rq;
      drive(($urandom_range(3) != 0), rq, ($urandom_range(2999) == 0));
    end
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vga_frame_sched.md
Name: vga_frame_sched

Overview:
- Timing and scheduling controller for the 640x480@60 VGA path, running on the 25 MHz pixel clock.
- Sequences the horizontal and vertical raster counters and generates sync, blanking and line/frame strobes.
- Arbitrates the shared tile/frame state between the renderer and the game-logic updater. The updater gets exclusive write access only during vertical blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- pix_en  in  1  advance enable; counters step only when 1
- h_count  out  10  pixel column, 0..H_TOTAL-1 (H_TOTAL = 800)
- v_count  out  10  line, 0..V_TOTAL-1 (V_TOTAL = 525)
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  1 when h_count<H_ACTIVE and v_count<V_ACTIVE
- line_start  out  1  one-cycle pulse when h_count becomes 0
- frame_start  out  1  one-cycle pulse when (h,v) becomes (0,0)
- upd_req  in  1  updater requests the shared state (level)
- upd_gnt  out  1  updater owns the shared state
- upd_overrun  out  1  one-cycle pulse: grant revoked by active video

Behaviour:
- Reset (rst=1 at clk edge):
  - h_count=0, v_count=0, video_on=1.
  - hsync and vsync inactive (=!SYNC_POL).
  - line_start=0, frame_start=0, upd_gnt=0, upd_overrun=0.
  - Arbiter FSM to IDLE. Reset mid-grant drops upd_gnt on the next edge with no overrun pulse.
- Counters:
  - On pix_en=1: h_count increments. At H_TOTAL-1 it wraps to 0 and v_count increments.
  - v_count wraps from V_TOTAL-1 to 0 on the same edge as the h wrap.
  - pix_en=0 freezes all counters and all registered outputs; strobes are 0.
- Horizontal phase FSM: ACTIVE -> FP -> SYNC -> BP -> ACTIVE. Boundaries are h_count = 640, 656, 752, 0.
- Vertical phase FSM: same structure, boundaries v_count = 480, 490, 492, 0. Transitions occur only on the h-wrap edge.
- Output timing:
  - All outputs are registered and aligned with the count values they describe, computed from the next-count.
  - hsync is active for h_count 656..751. vsync is active for v_count 490..491.
  - line_start and frame_start are high in the cycle the counts show 0 / (0,0), for exactly one pix_en step.
- Arbiter FSM (states IDLE, WAIT, GRANT, HOLD):
  - IDLE: upd_req=1 and in vblank (v_count>=V_ACTIVE) and v_count != V_TOTAL-1 -> GRANT. upd_gnt=1 on the next edge (1-cycle latency). A request under any other condition -> WAIT.
  - WAIT: enter GRANT on the first cycle the IDLE grant condition holds. If upd_req falls first -> IDLE.
  - GRANT: upd_gnt=1. upd_req=0 -> IDLE, upd_gnt=0 on the next edge. If the frame_start edge arrives with upd_req=1 -> HOLD: upd_gnt=0 and upd_overrun=1 in the frame_start cycle.
  - HOLD: upd_gnt=0 until upd_req is seen 0, then IDLE. Re-grant needs a fresh request.
  - Release and frame_start on the same edge: release wins, no overrun.
- Invariant: upd_gnt=1 and video_on=1 never occur in the same cycle.
- Arbiter state transitions are evaluated only on pix_en=1 cycles.

Optional Feature:
- Macro: VGA_FRAME_SCHED_FRAME_CNT_EN.
- Defined: adds output frame_count[15:0]. It resets to 0, increments by 1 on each frame_start and wraps 65535->0; it is used by the game for tile scroll pacing.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset then pix_en=1 for 420000 cycles:
  - frame_start pulses every 420000 cycles and line_start every 800 cycles.
  - hsync is low for exactly 96 cycles per line, starting at h=656.
  - vsync is low for 1600 cycles per frame.
- Set pix_en=1 on alternate cycles: the counts step every 2 clocks; the line period is 1600 clocks; each strobe is high for exactly 1 clock.
- upd_req=1 at (h=100, v=200):
  - upd_gnt stays 0; it rises 1 cycle after (h=0, v=480).
  - Drop upd_req at v=500: upd_gnt falls the next cycle; upd_overrun stays 0.
- Hold upd_req=1 through a whole vblank:
  - upd_gnt falls at frame_start; upd_overrun=1 for 1 cycle.
  - upd_gnt stays 0 for the rest of the frame until upd_req toggles 0 then 1 in the next vblank.
- Assert rst=1 at (h=300, v=510) with upd_gnt=1: on the next edge, counts=0, upd_gnt=0, upd_overrun=0, sync outputs inactive.
- Raise upd_req first at v=524: upd_gnt stays 0 through frame_start and the whole of the next frame's active region. Grant occurs at v=480, 1 cycle after (h=0, v=480).
